fat_update_sequencer: RTL and testbench



---
 rtl/fat_pkg.sv | 29 ++
 rtl/fat_entry_gen.sv | 30 +++
 rtl/fat_update_sequencer.sv | 141 ++++++++++++++
 tb/tb_fat_update_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fat_pkg.sv
// Shared types and FAT32 constants for the FAT update sequencer.
// Mirrored FAT2 write is enabled by defining FAT_MIRROR_EN.
package fat_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_STREAM,
    S_WAIT_DONE,
    S_NEXT,
    S_DONE,
    S_ERROR
  } fat_state_t;

  localparam logic [31:0] FAT_EOC        = 32'h0FFF_FFFF;
  localparam logic [31:0] FAT_MEDIA      = 32'h0FFF_FFF8;
  localparam logic [31:0] FAT_ENTRY_MASK = 32'h0FFF_FFFF;

  localparam int ENTRIES_PER_SECTOR = 128;
  localparam int BYTES_PER_SECTOR   = 512;

  function automatic logic [7:0] entry_byte(
    input logic [31:0] e,
    input logic [1:0]  lane
  );
    return e[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/fat_entry_gen.sv
// Combinational FAT32 entry value for cluster base + idx.
// Chain geometry only; no state.
module fat_entry_gen
  import fat_pkg::*;
#(
  parameter int unsigned FIRST_FILE_CLUST = 4
) (
  input  logic [31:0] base,
  input  logic [6:0]  idx,
  input  logic [31:0] eof,
  output logic [31:0] entry
);

  logic [31:0] c;

  assign c = base + {25'd0, idx};

  always_comb begin
    entry = '0;
    if (c == 32'd0)
      entry = FAT_MEDIA;
    else if (c < 32'(FIRST_FILE_CLUST))
      entry = FAT_EOC;
    else if (c < eof)
      entry = (c + 32'd1) & FAT_ENTRY_MASK;
    else if (c == eof)
      entry = FAT_EOC;
  end

endmodule

// File: rtl/fat_update_sequencer.sv
// Streams one FAT32 sector to the SD writer at FAT1 (and FAT2 when
// FAT_MIRROR_EN is defined); all outputs registered.
module fat_update_sequencer
  import fat_pkg::*;
#(
  parameter int unsigned FIRST_FILE_CLUST = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [31:0] FIRST_CLUST_TO_UPDATE_FAT,
  input  logic [31:0] CLUST_NUM_EOF,
  input  logic [31:0] ADDR_TO_UPDATE_FAT1,
  input  logic [31:0] ADDR_TO_UPDATE_FAT2,
  output logic        WR_REQ,
  output logic [31:0] WR_ADDR,
  input  logic        WR_ACK,
  output logic [7:0]  DATA_OUT,
  output logic        DATA_VALID,
  input  logic        DATA_READY,
  input  logic        WR_DONE,
  input  logic        WR_ERR,
  output logic        BUSY,
  output logic        COMPLT,
  output logic        ERR
);

  localparam logic [8:0] LAST_BYTE = 9'(BYTES_PER_SECTOR - 1);

  fat_state_t  state;
  logic        copy;
  logic [8:0]  k;
  logic [8:0]  sel;
  logic [31:0] base_q;
  logic [31:0] eof_q;
  logic [31:0] addr2_q;
  logic [31:0] entry;

  // Byte about to be registered: next counter in STREAM, byte 0 on WR_ACK.
  assign sel = (state == S_STREAM) ? k + 9'd1 : 9'd0;

  fat_entry_gen #(
    .FIRST_FILE_CLUST(FIRST_FILE_CLUST)
  ) u_gen (
    .base (base_q),
    .idx  (sel[8:2]),
    .eof  (eof_q),
    .entry(entry)
  );

`ifndef FAT_MIRROR_EN
  logic unused_cfg;
  assign unused_cfg = ^{addr2_q, copy};
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      copy       <= 1'b0;
      k          <= '0;
      base_q     <= '0;
      eof_q      <= '0;
      addr2_q    <= '0;
      WR_REQ     <= 1'b0;
      WR_ADDR    <= '0;
      DATA_OUT   <= '0;
      DATA_VALID <= 1'b0;
      BUSY       <= 1'b0;
      COMPLT     <= 1'b0;
      ERR        <= 1'b0;
    end else if (WR_ERR) begin
      state      <= S_ERROR;
      WR_REQ     <= 1'b0;
      DATA_VALID <= 1'b0;
      BUSY       <= 1'b0;
      COMPLT     <= 1'b0;
      ERR        <= 1'b1;
    end else begin
      unique case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (START) begin
            base_q  <= FIRST_CLUST_TO_UPDATE_FAT - 32'd1;
            eof_q   <= CLUST_NUM_EOF;
            addr2_q <= ADDR_TO_UPDATE_FAT2;
            WR_ADDR <= ADDR_TO_UPDATE_FAT1;
            copy    <= 1'b0;
            COMPLT  <= 1'b0;
            ERR     <= 1'b0;
            WR_REQ  <= 1'b1;
            BUSY    <= 1'b1;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (WR_ACK) begin
            WR_REQ     <= 1'b0;
            k          <= '0;
            DATA_OUT   <= entry_byte(entry, sel[1:0]);
            DATA_VALID <= 1'b1;
            state      <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (DATA_VALID && DATA_READY) begin
            if (k == LAST_BYTE) begin
              DATA_VALID <= 1'b0;
              state      <= S_WAIT_DONE;
            end else begin
              k        <= k + 9'd1;
              DATA_OUT <= entry_byte(entry, sel[1:0]);
            end
          end
        end
        S_WAIT_DONE: begin
          if (WR_DONE)
            state <= S_NEXT;
        end
        S_NEXT: begin
`ifdef FAT_MIRROR_EN
          if (!copy) begin
            copy    <= 1'b1;
            WR_ADDR <= addr2_q;
            WR_REQ  <= 1'b1;
            state   <= S_REQ;
          end else begin
            BUSY   <= 1'b0;
            COMPLT <= 1'b1;
            state  <= S_DONE;
          end
`else
          BUSY   <= 1'b0;
          COMPLT <= 1'b1;
          state  <= S_DONE;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fat_update_sequencer.sv
// Directed bench for fat_update_sequencer.
// Follows FAT_MIRROR_EN to expect one or two sector writes.
module tb_fat_update_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [31:0] first;
  logic [31:0] eof;
  logic [31:0] a1;
  logic [31:0] a2;
  logic        WR_REQ;
  logic [31:0] WR_ADDR;
  logic        WR_ACK;
  logic [7:0]  DATA_OUT;
  logic        DATA_VALID;
  logic        DATA_READY;
  logic        WR_DONE;
  logic        WR_ERR;
  logic        BUSY;
  logic        COMPLT;
  logic        ERR;

  int n_chk  = 0;
  int n_fail = 0;
  int n_req  = 0;
  logic req_d = 1'b0;

  logic [7:0] rx [512];
  int n_rx;

  fat_update_sequencer dut (
    .CLK                      (CLK),
    .RST                      (RST),
    .START                    (START),
    .FIRST_CLUST_TO_UPDATE_FAT(first),
    .CLUST_NUM_EOF            (eof),
    .ADDR_TO_UPDATE_FAT1      (a1),
    .ADDR_TO_UPDATE_FAT2      (a2),
    .WR_REQ                   (WR_REQ),
    .WR_ADDR                  (WR_ADDR),
    .WR_ACK                   (WR_ACK),
    .DATA_OUT                 (DATA_OUT),
    .DATA_VALID               (DATA_VALID),
    .DATA_READY               (DATA_READY),
    .WR_DONE                  (WR_DONE),
    .WR_ERR                   (WR_ERR),
    .BUSY                     (BUSY),
    .COMPLT                   (COMPLT),
    .ERR                      (ERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    req_d <= WR_REQ;
    if (WR_REQ && !req_d) n_req++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] spec_entry(input logic [31:0] base,
                                             input int i,
                                             input logic [31:0] e);
    logic [31:0] c;
    c = base + 32'(i);
    if (c == 0)      return 32'h0FFF_FFF8;
    if (c < 4)       return 32'h0FFF_FFFF;
    if (c < e)       return (c + 1) & 32'h0FFF_FFFF;
    if (c == e)      return 32'h0FFF_FFFF;
    return 32'h0;
  endfunction

  function automatic logic [31:0] rx_entry(input int i);
    return {rx[4*i+3], rx[4*i+2], rx[4*i+1], rx[4*i]};
  endfunction

  task automatic start_run(input logic [31:0] base, input logic [31:0] e);
    first = base + 1;
    eof   = e;
    START = 1'b1;
    step;
    START = 1'b0;
    chk("start_req", WR_REQ, 1);
    chk("start_busy", BUSY, 1);
    chk("start_addr", WR_ADDR, a1);
    chk("start_err", ERR, 0);
    chk("start_complt", COMPLT, 0);
  endtask

  task automatic ack(input string tag);
    step;
    chk({tag, "_req_hold"}, WR_REQ, 1);
    WR_ACK = 1'b1;
    step;
    WR_ACK = 1'b0;
    chk({tag, "_req_drop"}, WR_REQ, 0);
    chk({tag, "_valid"}, DATA_VALID, 1);
  endtask

  task automatic stream(input int mode, input int stop_at, input bit poke,
                        output int cycles);
    bit r;
    bit held_v;
    bit poked;
    logic [7:0] held;
    int stall_bad;
    n_rx = 0;
    cycles = 0;
    held_v = 0;
    poked = 0;
    stall_bad = 0;
    held = '0;
    while (n_rx < stop_at && cycles < 4000) begin
      if (held_v && (DATA_OUT !== held || DATA_VALID !== 1'b1))
        stall_bad++;
      r = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      START = 1'b0;
      if (poke && !poked && n_rx == 100) begin
        START = 1'b1;
        first = 32'h0000_5555;
        poked = 1;
      end
      DATA_READY = r;
      if (DATA_VALID && r) begin
        rx[n_rx] = DATA_OUT;
        n_rx++;
        held_v = 0;
      end else if (DATA_VALID) begin
        held = DATA_OUT;
        held_v = 1;
      end else begin
        held_v = 0;
      end
      step;
      cycles++;
    end
    START = 1'b0;
    DATA_READY = 1'b0;
    chk("stream_count", n_rx, stop_at);
    chk("stall_hold", stall_bad, 0);
  endtask

  task automatic check_page(input string tag, input logic [31:0] base,
                            input logic [31:0] e);
    for (int i = 0; i < 128; i++)
      chk(tag, rx_entry(i), spec_entry(base, i, e));
  endtask

  task automatic close_copy;
    step;
    chk("wait_busy", BUSY, 1);
    WR_DONE = 1'b1;
    step;
    WR_DONE = 1'b0;
    chk("next_busy", BUSY, 1);
    step;
  endtask

  task automatic full_update(input logic [31:0] base, input logic [31:0] e,
                             input int mode, input string tag);
    int cyc;
    start_run(base, e);
    ack({tag, "_f1"});
    stream(mode, 512, 0, cyc);
    check_page({tag, "_f1"}, base, e);
    chk("valid_drop", DATA_VALID, 0);
    if (mode == 0) chk("stream_cycles", cyc, 512);
    close_copy;
`ifdef FAT_MIRROR_EN
    chk("f2_req", WR_REQ, 1);
    chk("f2_addr", WR_ADDR, a2);
    chk("f2_complt", COMPLT, 0);
    ack({tag, "_f2"});
    stream(mode, 512, 0, cyc);
    check_page({tag, "_f2"}, base, e);
    chk("valid_drop2", DATA_VALID, 0);
    close_copy;
`endif
    chk("done_complt", COMPLT, 1);
    chk("done_busy", BUSY, 0);
    chk("done_req", WR_REQ, 0);
    chk("done_err", ERR, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, WR_REQ, 0);
    chk({tag, "_valid"}, DATA_VALID, 0);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_complt"}, COMPLT, 0);
    chk({tag, "_err"}, ERR, 0);
    chk({tag, "_addr"}, WR_ADDR, 0);
    chk({tag, "_data"}, DATA_OUT, 0);
  endtask

  initial begin
    int cyc;
    int req0;
    RST = 1'b1;
    START = 1'b0;
    WR_ACK = 1'b0;
    DATA_READY = 1'b0;
    WR_DONE = 1'b0;
    WR_ERR = 1'b0;
    first = '0;
    eof = '0;
    a1 = 32'h0000_2000;
    a2 = 32'h0000_3000;
    step;
    step;
    check_reset_outputs("rst");
    RST = 1'b0;
    step;

    // BASE 0, EOF 10: media, reserved, links, EOC, free
    req0 = n_req;
    full_update(32'd0, 32'd10, 0, "p0");
    chk("e0", rx_entry(0), 32'h0FFF_FFF8);
    chk("e3", rx_entry(3), 32'h0FFF_FFFF);
    chk("e4", rx_entry(4), 32'd5);
    chk("e9", rx_entry(9), 32'd10);
    chk("e10", rx_entry(10), 32'h0FFF_FFFF);
    chk("e11", rx_entry(11), 32'h0);
    chk("e127", rx_entry(127), 32'h0);
    chk("b16", rx[16], 8'h05);
    chk("b17", rx[17], 8'h00);
    chk("b18", rx[18], 8'h00);
    chk("b19", rx[19], 8'h00);
`ifdef FAT_MIRROR_EN
    chk("req_count", n_req - req0, 2);
`else
    chk("req_count", n_req - req0, 1);
`endif

    // BASE 128, EOF 300: whole page is chain links
    full_update(32'd128, 32'd300, 0, "p128");
    chk("p128_e0", rx_entry(0), 32'd129);
    chk("p128_e127", rx_entry(127), 32'd256);

    // Random READY stalls
    full_update(32'd100, 32'd150, 1, "rnd");
    chk("rnd_e50", rx_entry(50), 32'h0FFF_FFFF);

    // EOF below BASE: file range all zero
    full_update(32'd200, 32'd50, 0, "eoflo");
    chk("eoflo_e5", rx_entry(5), 32'h0);

    // Writer error mid-stream, then clean restart
    start_run(32'd0, 32'd10);
    ack("err");
    stream(0, 200, 0, cyc);
    WR_ERR = 1'b1;
    DATA_READY = 1'b1;
    step;
    WR_ERR = 1'b0;
    DATA_READY = 1'b0;
    chk("err_flag", ERR, 1);
    chk("err_valid", DATA_VALID, 0);
    chk("err_req", WR_REQ, 0);
    chk("err_busy", BUSY, 0);
    step;
    chk("err_hold", ERR, 1);
    full_update(32'd0, 32'd10, 0, "restart");

    // START during STREAM ignored; RST in WAIT_DONE
    start_run(32'd0, 32'd10);
    ack("rstw");
    stream(1, 512, 1, cyc);
    check_page("poke", 32'd0, 32'd10);
    chk("poke_addr", WR_ADDR, a1);
    step;
    chk("rstw_busy", BUSY, 1);
    RST = 1'b1;
    step;
    RST = 1'b0;
    check_reset_outputs("rstw");
    step;
    chk("rstw_idle", BUSY, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
